// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the 4x8 register file: ALU (port 0) and load unit (port 1)
// share one write port, with a pending-write scoreboard for decode read stalls.
module regfile_write_arbiter #(
  parameter bit RR_EN = 1'b1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_valid,
  input  logic [1:0]       alu_reg,
  input  logic [7:0]       alu_value,
  output logic             alu_ready,
  input  logic             mem_valid,
  input  logic [1:0]       mem_reg,
  input  logic [7:0]       mem_value,
  output logic             mem_ready,
  input  logic             alloc_en,
  input  logic [1:0]       alloc_reg,
  output logic             rf_write_en,
  output logic [1:0]       rf_write_reg,
  output logic [7:0]       rf_write_value,
  output logic [3:0]       busy,
  output logic             alloc_err,
  output logic [CNT_W-1:0] write_count
);

  // Handshake: a transfer happens on any cycle where valid && ready. A requester
  // holds valid/reg/value stable until ready; ready is combinational from the
  // valids and registered state, and there is no buffering, so the loser stalls.

  logic       last_grant;  // 0 = ALU, 1 = MEM
  logic       grant_alu;
  logic       grant_mem;
  logic [3:0] clr_mask;
  logic [3:0] set_mask;
  logic       alloc_conflict;

  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (!reset) begin
      if (alu_valid && mem_valid) begin
        if (RR_EN) begin
          grant_alu = last_grant;
          grant_mem = ~last_grant;
        end else begin
          grant_alu = 1'b1;
        end
      end else begin
        grant_alu = alu_valid;
        grant_mem = mem_valid;
      end
    end
  end

  assign alu_ready   = grant_alu;
  assign mem_ready   = grant_mem;
  assign rf_write_en = grant_alu | grant_mem;

  // Data path is forced to zero with no grant so nothing undriven reaches the file.
  always_comb begin
    rf_write_reg   = 2'd0;
    rf_write_value = 8'd0;
    if (grant_alu) begin
      rf_write_reg   = alu_reg;
      rf_write_value = alu_value;
    end else if (grant_mem) begin
      rf_write_reg   = mem_reg;
      rf_write_value = mem_value;
    end
  end

  always_comb begin
    clr_mask = 4'd0;
    set_mask = 4'd0;
    if (rf_write_en) clr_mask = 4'b0001 << rf_write_reg;
    if (alloc_en)    set_mask = 4'b0001 << alloc_reg;
  end

  // Allocating a register whose pending write retires this same cycle is legal.
  assign alloc_conflict = alloc_en && busy[alloc_reg] &&
                          !(rf_write_en && (rf_write_reg == alloc_reg));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy        <= 4'd0;
      alloc_err   <= 1'b0;
      write_count <= '0;
      last_grant  <= 1'b1;
    end else begin
      busy <= (busy & ~clr_mask) | set_mask;
      if (alloc_conflict) alloc_err <= 1'b1;
      if (rf_write_en) begin
        write_count <= write_count + CNT_W'(1);
        last_grant  <= grant_mem;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level reference model of the arbitration rules.
module tb_regfile_write_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       alu_valid, mem_valid, alloc_en;
  logic [1:0] alu_reg, mem_reg, alloc_reg;
  logic [7:0] alu_value, mem_value;
  logic       alu_ready, mem_ready, rf_write_en, alloc_err;
  logic [1:0] rf_write_reg;
  logic [7:0] rf_write_value, write_count;
  logic [3:0] busy;

  // fixed-priority instance
  logic       fp_alu_valid, fp_mem_valid;
  logic       fp_alu_ready, fp_mem_ready, fp_rf_write_en, fp_alloc_err;
  logic [1:0] fp_rf_write_reg;
  logic [7:0] fp_rf_write_value, fp_write_count;
  logic [3:0] fp_busy;

  int checks = 0;
  int failures = 0;

  // reference model state
  bit m_busy[4];
  bit m_err;
  int m_cnt;
  int m_last;  // 0 = ALU, 1 = MEM
  int m_gnt;   // grant of the most recent cycle, -1 = none

  regfile_write_arbiter #(.RR_EN(1'b1), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_value(alu_value), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_value(mem_value), .mem_ready(mem_ready),
    .alloc_en(alloc_en), .alloc_reg(alloc_reg),
    .rf_write_en(rf_write_en), .rf_write_reg(rf_write_reg), .rf_write_value(rf_write_value),
    .busy(busy), .alloc_err(alloc_err), .write_count(write_count)
  );

  regfile_write_arbiter #(.RR_EN(1'b0), .CNT_W(8)) dut_fp (
    .clk(clk), .reset(reset),
    .alu_valid(fp_alu_valid), .alu_reg(2'd1), .alu_value(8'h11), .alu_ready(fp_alu_ready),
    .mem_valid(fp_mem_valid), .mem_reg(2'd3), .mem_value(8'h33), .mem_ready(fp_mem_ready),
    .alloc_en(1'b0), .alloc_reg(2'd0),
    .rf_write_en(fp_rf_write_en), .rf_write_reg(fp_rf_write_reg), .rf_write_value(fp_rf_write_value),
    .busy(fp_busy), .alloc_err(fp_alloc_err), .write_count(fp_write_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_busy();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_busy[i] = 1'b0;
    m_err  = 1'b0;
    m_cnt  = 0;
    m_last = 1;
    m_gnt  = -1;
  endtask

  task automatic set_inputs(input logic av, input logic [1:0] ar, input logic [7:0] ad,
                            input logic mv, input logic [1:0] mr, input logic [7:0] md,
                            input logic ae, input logic [1:0] areg);
    alu_valid = av; alu_reg = ar; alu_value = ad;
    mem_valid = mv; mem_reg = mr; mem_value = md;
    alloc_en = ae;  alloc_reg = areg;
  endtask

  // One clock: check outputs at negedge against the model, then advance the model.
  task automatic step();
    int g;
    logic [1:0] greg;
    logic [7:0] gval;
    @(negedge clk);
    g = -1;
    if (alu_valid && mem_valid) g = 1 - m_last;
    else if (alu_valid) g = 0;
    else if (mem_valid) g = 1;
    greg = (g == 0) ? alu_reg : (g == 1) ? mem_reg : 2'd0;
    gval = (g == 0) ? alu_value : (g == 1) ? mem_value : 8'd0;
    check("alu_ready", alu_ready, g == 0);
    check("mem_ready", mem_ready, g == 1);
    check("rf_write_en", rf_write_en, g >= 0);
    check("rf_write_reg", rf_write_reg, greg);
    check("rf_write_value", rf_write_value, gval);
    check("busy", busy, model_busy());
    check("alloc_err", alloc_err, m_err);
    check("write_count", write_count, m_cnt);
    @(posedge clk);
    if (alloc_en && m_busy[alloc_reg] && !(g >= 0 && greg == alloc_reg)) m_err = 1'b1;
    if (g >= 0) begin
      m_busy[greg] = 1'b0;
      m_cnt = (m_cnt + 1) % 256;
      m_last = g;
    end
    if (alloc_en) m_busy[alloc_reg] = 1'b1;
    m_gnt = g;
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic apply_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_busy", busy, 4'd0);
    check("rst_alu_ready", alu_ready, 1'b0);
    check("rst_mem_ready", mem_ready, 1'b0);
    check("rst_wen", rf_write_en, 1'b0);
    check("rst_count", write_count, 8'd0);
    check("rst_err", alloc_err, 1'b0);
    model_reset();
    set_inputs(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    fp_alu_valid = 1'b0;
    fp_mem_valid = 1'b0;
    set_inputs(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: single ALU write
    set_inputs(1, 2'd2, 8'h5A, 0, 0, 0, 0, 0);
    step();
    check("t1_count", write_count, 8'd1);
    set_inputs(0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // 2: contention, round-robin then fixed priority
    apply_reset();
    set_inputs(1, 2'd1, 8'h11, 1, 2'd3, 8'h33, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t2_rr_order", m_gnt, i % 2);
    end
    set_inputs(0, 0, 0, 0, 0, 0, 0, 0);
    fp_alu_valid = 1'b1;
    fp_mem_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_fp_alu_ready", fp_alu_ready, 1'b1);
      check("t2_fp_mem_ready", fp_mem_ready, 1'b0);
      check("t2_fp_wreg", fp_rf_write_reg, 2'd1);
      check("t2_fp_wval", fp_rf_write_value, 8'h11);
    end
    fp_alu_valid = 1'b0;
    fp_mem_valid = 1'b0;
    step();

    // 3: alloc r0, later retired by a load write
    apply_reset();
    set_inputs(0, 0, 0, 0, 0, 0, 1, 2'd0);
    step();
    check("t3_busy_set", busy, 4'b0001);
    set_inputs(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    set_inputs(0, 0, 0, 1, 2'd0, 8'h7F, 0, 0);
    step();
    check("t3_busy_clr", busy, 4'b0000);
    check("t3_no_err", alloc_err, 1'b0);

    // 4: clear+alloc same register, then a genuine double alloc
    apply_reset();
    set_inputs(0, 0, 0, 0, 0, 0, 1, 2'd2);
    step();
    set_inputs(1, 2'd2, 8'hA5, 0, 0, 0, 1, 2'd2);
    step();
    check("t4_busy_kept", busy, 4'b0100);
    check("t4_no_err", alloc_err, 1'b0);
    set_inputs(0, 0, 0, 0, 0, 0, 1, 2'd2);
    step();
    check("t4_err_set", alloc_err, 1'b1);
    set_inputs(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    check("t4_err_sticky", alloc_err, 1'b1);

    // 5: reset during contention with busy=1010
    apply_reset();
    set_inputs(0, 0, 0, 0, 0, 0, 1, 2'd1);
    step();
    set_inputs(0, 0, 0, 0, 0, 0, 1, 2'd3);
    step();
    check("t5_busy_pre", busy, 4'b1010);
    set_inputs(1, 2'd1, 8'h11, 1, 2'd3, 8'h33, 0, 0);
    step();
    apply_reset();
    set_inputs(1, 2'd1, 8'h11, 1, 2'd3, 8'h33, 0, 0);
    step();
    check("t5_alu_first", m_gnt, 0);

    // 6: 256 back-to-back ALU writes wrap the counter
    apply_reset();
    for (int i = 0; i < 256; i++) begin
      set_inputs(1, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 0, 0, 0, 0, 0);
      step();
    end
    check("t6_wrap", write_count, 8'd0);
    set_inputs(0, 0, 0, 0, 0, 0, 0, 0);

    // randomized traffic obeying the hold-until-ready rule
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 79) == 0) apply_reset();
      if (!alu_valid || m_gnt == 0) begin
        alu_valid = 1'($urandom_range(0, 1));
        alu_reg   = 2'($urandom_range(0, 3));
        alu_value = 8'($urandom_range(0, 255));
      end
      if (!mem_valid || m_gnt == 1) begin
        mem_valid = 1'($urandom_range(0, 1));
        mem_reg   = 2'($urandom_range(0, 3));
        mem_value = 8'($urandom_range(0, 255));
      end
      alloc_en  = ($urandom_range(0, 3) == 0);
      alloc_reg = 2'($urandom_range(0, 3));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
